// File: rtl/ex_stage_if.sv
// ID/EX operand/control bundle into the execute stage and the EX/MEM
// register bundle it drives toward the MEM stage.
interface ex_stage_if;
    logic        id_valid;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic [31:0] Imm32;
    logic        ALUSrc;
    logic [3:0]  ALUFun;
    logic [4:0]  id_WriteReg;
    logic        id_MemRead;
    logic        id_MemWrite;
    logic        id_RegWrite;
    logic        id_LUOp;
    logic [1:0]  id_MemToReg;
    logic [31:0] id_PC_Plus4;
    logic [31:0] id_LUData;

    logic [31:0] ALU_S;
    logic [31:0] MemWriteData;
    logic [31:0] PC_Plus4;
    logic [31:0] LUData;
    logic [4:0]  WriteReg;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        LUOp;
    logic [1:0]  MemToReg;

    modport master (
        output id_valid, Rs, Rt, RsData, RtData, Imm32, ALUSrc, ALUFun, id_WriteReg,
               id_MemRead, id_MemWrite, id_RegWrite, id_LUOp, id_MemToReg,
               id_PC_Plus4, id_LUData,
        input  ALU_S, MemWriteData, PC_Plus4, LUData, WriteReg, MemRead, MemWrite,
               RegWrite, LUOp, MemToReg
    );

    modport slave (
        input  id_valid, Rs, Rt, RsData, RtData, Imm32, ALUSrc, ALUFun, id_WriteReg,
               id_MemRead, id_MemWrite, id_RegWrite, id_LUOp, id_MemToReg,
               id_PC_Plus4, id_LUData,
        output ALU_S, MemWriteData, PC_Plus4, LUData, WriteReg, MemRead, MemWrite,
               RegWrite, LUOp, MemToReg
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiplier
// that stalls upstream, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int MUL_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [37:0] MEM_WB,
    output logic        stall,
    ex_stage_if.slave   bus
);
    localparam int       MUL_ITERS = 32 / MUL_BITS;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;

    logic [31:0] alu_s_q, alu_s_d, mwd_q, mwd_d, pc4_q, pc4_d, lud_q, lud_d;
    logic [4:0]  wr_q, wr_d;
    logic        mr_q, mr_d, mw_q, mw_d, rw_q, rw_d, lu_q, lu_d;
    logic [1:0]  mtr_q, mtr_d;

    logic        ex_fwd_en_s, stall_s, load_s;
    logic [31:0] ex_val_s, fwd_rs_s, fwd_rt_s, op_a_s, op_b_s, alu_s, pp_sum_s;

    function automatic logic [31:0] fwd_value(
        input logic [4:0]  src,
        input logic [31:0] rf_data,
        input logic        ex_en,
        input logic [4:0]  ex_wr,
        input logic [31:0] ex_val,
        input logic [37:0] wb
    );
        logic [31:0] v;
        if (ex_en && (ex_wr != 5'd0) && (ex_wr == src)) begin
            v = ex_val;
        end else if (wb[37] && (wb[36:32] != 5'd0) && (wb[36:32] == src)) begin
            v = wb[31:0];
        end else begin
            v = rf_data;
        end
        return v;
    endfunction

    // Forwarded operands; a load in EX/MEM has no data yet, so it never forwards
    always_comb begin
        ex_fwd_en_s = rw_q & ~mr_q;
        ex_val_s    = lu_q ? lud_q : ((mtr_q == 2'd2) ? pc4_q : alu_s_q);
        fwd_rs_s    = fwd_value(bus.Rs, bus.RsData, ex_fwd_en_s, wr_q, ex_val_s, MEM_WB);
        fwd_rt_s    = fwd_value(bus.Rt, bus.RtData, ex_fwd_en_s, wr_q, ex_val_s, MEM_WB);
        op_a_s      = fwd_rs_s;
        op_b_s      = bus.ALUSrc ? bus.Imm32 : fwd_rt_s;
    end

    // ALU result; MUL selects the finished product held in the accumulator
    always_comb begin
        alu_s = 32'd0;
        case (bus.ALUFun)
            4'd0:    alu_s = op_a_s + op_b_s;
            4'd1:    alu_s = op_a_s - op_b_s;
            4'd2:    alu_s = op_a_s & op_b_s;
            4'd3:    alu_s = op_a_s | op_b_s;
            4'd4:    alu_s = op_a_s ^ op_b_s;
            4'd5:    alu_s = ~(op_a_s | op_b_s);
            4'd6:    alu_s = op_b_s << op_a_s[4:0];
            4'd7:    alu_s = op_b_s >> op_a_s[4:0];
            4'd8:    alu_s = $unsigned($signed(op_b_s) >>> op_a_s[4:0]);
            4'd9:    alu_s = {31'd0, $signed(op_a_s) < $signed(op_b_s)};
            4'd10:   alu_s = {31'd0, op_a_s < op_b_s};
            4'd11:   alu_s = acc_q;
            default: alu_s = 32'd0;
        endcase
    end

    // One multiplier step: add MUL_BITS shifted partial products
    always_comb begin
        pp_sum_s = acc_q;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier_q[i]) begin
                pp_sum_s = pp_sum_s + (mcand_q << i);
            end else begin
                pp_sum_s = pp_sum_s;
            end
        end
    end

    // Multiplier FSM next state and stall
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        stall_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.id_valid && (bus.ALUFun == OP_MUL) && !flush) begin
                    stall_s  = 1'b1;
                    acc_d    = 32'd0;
                    mcand_d  = op_a_s;
                    mplier_d = op_b_s;
                    cnt_d    = 6'(MUL_ITERS);
                    state_d  = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    cnt_d   = 6'd0;
                    state_d = IDLE;
                end else begin
                    stall_s  = 1'b1;
                    acc_d    = pp_sum_s;
                    mcand_d  = mcand_q << MUL_BITS;
                    mplier_d = mplier_q >> MUL_BITS;
                    cnt_d    = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            DONE: begin
                cnt_d   = 6'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 6'd0;
                state_d = IDLE;
            end
        endcase
    end

    // EX/MEM next value: the instruction, or an all-zero bubble
    always_comb begin
        load_s   = bus.id_valid & ~flush & ~stall_s;
        alu_s_d  = 32'd0;
        mwd_d    = 32'd0;
        pc4_d    = 32'd0;
        lud_d    = 32'd0;
        wr_d     = 5'd0;
        mr_d     = 1'b0;
        mw_d     = 1'b0;
        rw_d     = 1'b0;
        lu_d     = 1'b0;
        mtr_d    = 2'd0;
        if (load_s) begin
            alu_s_d = alu_s;
            mwd_d   = fwd_rt_s;
            pc4_d   = bus.id_PC_Plus4;
            lud_d   = bus.id_LUData;
            wr_d    = bus.id_WriteReg;
            mr_d    = bus.id_MemRead;
            mw_d    = bus.id_MemWrite;
            rw_d    = bus.id_RegWrite;
            lu_d    = bus.id_LUOp;
            mtr_d   = bus.id_MemToReg;
        end else begin
            rw_d    = 1'b0;
        end
    end

    // State and EX/MEM registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            alu_s_q  <= 32'd0;
            mwd_q    <= 32'd0;
            pc4_q    <= 32'd0;
            lud_q    <= 32'd0;
            wr_q     <= 5'd0;
            mr_q     <= 1'b0;
            mw_q     <= 1'b0;
            rw_q     <= 1'b0;
            lu_q     <= 1'b0;
            mtr_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            alu_s_q  <= alu_s_d;
            mwd_q    <= mwd_d;
            pc4_q    <= pc4_d;
            lud_q    <= lud_d;
            wr_q     <= wr_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            rw_q     <= rw_d;
            lu_q     <= lu_d;
            mtr_q    <= mtr_d;
        end
    end

    assign stall            = stall_s & ~rst;
    assign bus.ALU_S        = alu_s_q;
    assign bus.MemWriteData = mwd_q;
    assign bus.PC_Plus4     = pc4_q;
    assign bus.LUData       = lud_q;
    assign bus.WriteReg     = wr_q;
    assign bus.MemRead      = mr_q;
    assign bus.MemWrite     = mw_q;
    assign bus.RegWrite     = rw_q;
    assign bus.LUOp         = lu_q;
    assign bus.MemToReg     = mtr_q;
endmodule
